// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit ripple-carry stage reused over WIDTH/4 cycles.
// Operands are captured on accept, then one nibble per cycle is summed
// LSB-first while the carry is kept in a register between slices.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned N    = WIDTH / 4;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sum_q;
    logic [IdxW-1:0]   idx_q;
    logic              carry_q;
    logic              cout_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [3:0]        stage_s;
    logic [4:0]        ripple_c;
    logic              stage_co;

    // Select the operand nibbles addressed by the current slice index.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int n = 0; n < int'(N); n++) begin
            if (idx_q == IdxW'(n)) begin
                nib_a = a_q[4*n +: 4];
                nib_b = b_q[4*n +: 4];
            end
        end
    end

    // The single shared 4-bit ripple-carry stage.
    always_comb begin
        ripple_c    = '0;
        stage_s     = '0;
        ripple_c[0] = carry_q;
        for (int k = 0; k < 4; k++) begin
            stage_s[k]    = nib_a[k] ^ nib_b[k] ^ ripple_c[k];
            ripple_c[k+1] = (nib_a[k] & nib_b[k]) | (ripple_c[k] & (nib_a[k] ^ nib_b[k]));
        end
        stage_co = ripple_c[4];
    end

    // Control FSM with registered handshake outputs; rst overrides every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    for (int n = 0; n < int'(N); n++) begin
                        if (idx_q == IdxW'(n)) begin
                            sum_q[4*n +: 4] <= stage_s;
                        end
                    end
                    carry_q <= stage_co;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        cout_q      <= stage_co;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    // Result held until the consumer takes it; no accept this cycle.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [15:0] a, b, sum;

    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
    logic [3:0]  a4, b4, sum4;

    int n_checks;
    int n_fail;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .busy      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accept one operation, wait (bounded) for the result and check it; stays in DONE.
    task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic [15:0] exp_sum, input logic exp_cout);
        int cyc;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        cin      = 1'b1;
        cyc      = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, ".latency"}, 32'(cyc), 32'd4);
        check({tag, ".sum"},     32'(sum),  32'(exp_sum));
        check({tag, ".cout"},    32'(cout), 32'(exp_cout));
    endtask

    // Consumer takes the result; block must be back in IDLE after that edge.
    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".done_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".done_ready"}, 32'(in_ready),  32'd1);
        check({tag, ".done_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        logic [15:0] held_sum;
        logic        held_cout;
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        a4         = '0;
        b4         = '0;
        cin4       = 1'b0;
        out_ready4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.busy",      32'(busy),      32'd0);
        check("rst.sum",       32'(sum),       32'd0);
        check("rst.cout",      32'(cout),      32'd0);

        do_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        check("t1.busy", 32'(busy), 32'd1);
        finish_op("t1");

        do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        finish_op("t2");

        do_op("t3a", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        finish_op("t3a");
        do_op("t3b", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
        finish_op("t3b");

        do_op("t3c", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        finish_op("t3c");

        // Backpressure: result must hold and new operands must be refused.
        do_op("t4", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0);
        held_sum  = sum;
        held_cout = cout;
        a         = 16'h1111;
        b         = 16'h1111;
        cin       = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("t4.hold%0d.valid", i), 32'(out_valid), 32'd1);
            check($sformatf("t4.hold%0d.ready", i), 32'(in_ready),  32'd0);
            check($sformatf("t4.hold%0d.sum", i),   32'(sum),       32'(held_sum));
            check($sformatf("t4.hold%0d.cout", i),  32'(cout),      32'(held_cout));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("t4.release_valid", 32'(out_valid), 32'd0);
        check("t4.release_ready", 32'(in_ready),  32'd1);
        check("t4.not_accepted",  32'(busy),      32'd0);

        // Reset in the second RUN cycle aborts the operation.
        a        = 16'h1234;
        b        = 16'h4321;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5.out_valid", 32'(out_valid), 32'd0);
        check("t5.sum",       32'(sum),       32'd0);
        check("t5.cout",      32'(cout),      32'd0);
        check("t5.in_ready",  32'(in_ready),  32'd1);
        check("t5.busy",      32'(busy),      32'd0);
        do_op("t5b", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);
        finish_op("t5b");

        // WIDTH=4 instance: single-cycle latency.
        check("t6.in_ready", 32'(in_ready4), 32'd1);
        a4        = 4'h9;
        b4        = 4'h8;
        cin4      = 1'b1;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        check("t6.valid_early", 32'(out_valid4), 32'd0);
        @(posedge clk);
        #1;
        check("t6.valid", 32'(out_valid4), 32'd1);
        check("t6.sum",   32'(sum4),       32'h2);
        check("t6.cout",  32'(cout4),      32'd1);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
        check("t6.done_valid", 32'(out_valid4), 32'd0);
        check("t6.done_ready", 32'(in_ready4),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
